// File: rtl/game_pkg.sv
// Shared game definitions: sprite frame codes, map geometry,
// boss FSM encoding and small map helpers.
package game_pkg;

  localparam int unsigned MAP_X0 = 60;
  localparam int unsigned MAP_Y0 = 30;
  localparam int unsigned CELL   = 5;
  localparam int unsigned SPRITE = 10;

  typedef enum logic [3:0] {
    UP1, UP2, UP3,
    RIGHT1, RIGHT2, RIGHT3,
    LEFT1, LEFT2, LEFT3,
    DOWN1, DOWN2, DOWN3
  } frame_e;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_PICK, S_LOOK_A,
    S_LOOK_B, S_COMMIT, S_CAUGHT
  } state_e;

  function automatic logic [5:0] cell_of(
    input logic [10:0] p,
    input int unsigned org
  );
    logic [10:0] t;
    t = p - 11'(org);
    return 6'(t / 11'(CELL));
  endfunction

  // axy=1 selects the y axis, neg=1 a step toward smaller coordinates
  function automatic logic [3:0] base_of(
    input logic axy,
    input logic neg
  );
    logic [3:0] b;
    unique case ({axy, neg})
      2'b00: b = 4'(RIGHT1);
      2'b01: b = 4'(LEFT1);
      2'b10: b = 4'(DOWN1);
      default: b = 4'(UP1);
    endcase
    return b;
  endfunction

endpackage

// File: rtl/move_tick_gen.sv
// Move-attempt tick divider; BOSS_SPEEDUP_EN halves the period
// once all three keys are held and restarts the count on key change.
module move_tick_gen #(
  parameter int unsigned TICK_DIV = 4194304
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] key_find_i,
  output logic       tick_o
);

  logic [31:0] cnt_q, cnt_d, last;
  logic        clr;

`ifdef BOSS_SPEEDUP_EN
  logic [1:0] key_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) key_q <= '0;
    else         key_q <= key_find_i;
  end

  assign last = (key_find_i == 2'd3) ?
                32'(TICK_DIV / 2 - 1) :
                32'(TICK_DIV - 1);
  assign clr  = key_q != key_find_i;
`else
  logic unused_key;
  assign unused_key = ^key_find_i;
  assign last = 32'(TICK_DIV - 1);
  assign clr  = 1'b0;
`endif

  assign tick_o = en_i && !clr && (cnt_q >= last);

  always_comb begin
    cnt_d = cnt_q + 32'd1;
    if (!en_i || clr || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/boss_chase_ctrl.sv
// Stage-3 boss chaser: steps toward the player each tick after two
// wall-map lookups. Optional BOSS_SPEEDUP_EN lives in move_tick_gen.
module boss_chase_ctrl
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 4194304,
  parameter int unsigned START_X    = 240,
  parameter int unsigned START_Y    = 185,
  parameter int unsigned CATCH_DIST = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [8:0] player_x,
  input  logic [8:0] player_y,
  input  logic [1:0] key_find,
  output logic       map_req,
  output logic [5:0] map_row,
  output logic [5:0] map_col,
  input  logic       map_ack,
  input  logic       map_wall,
  output logic [8:0] boss_x,
  output logic [8:0] boss_y,
  output logic [3:0] boss_state,
  output logic       caught
);

  state_e      state_q, state_d;
  logic [8:0]  bx_q, bx_d, by_q, by_d;
  logic [3:0]  st_q, st_d;
  logic        req_q, req_d, caught_q, caught_d;
  logic [5:0]  row_q, row_d, col_q, col_d;
  logic [10:0] nx_q, nx_d, ny_q, ny_d;
  logic        axy_q, axy_d, neg_q, neg_d;
  logic        snz_q, snz_d, sneg_q, sneg_d;
  logic        retry_q, retry_d, wa_q, wa_d;
  logic        blk_q, blk_d, null_q, null_d;
  logic        tick;

  logic signed [9:0] dx, dy;
  logic [9:0]  adx, ady;
  logic        pick_y, pick_neg, pick_null;
  logic        c_axy, c_neg;
  logic [10:0] c_step, cx, cy;
  logic        cand_bad, mv_ok, do_retry, catch_hit;
  logic [8:0]  cbx, cby;
  logic [3:0]  dir_b;

  function automatic logic near(
    input logic [8:0] a,
    input logic [8:0] b
  );
    logic [8:0] d;
    d = (a > b) ? a - b : b - a;
    return 32'(d) < CATCH_DIST;
  endfunction

  move_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (enable),
    .key_find_i (key_find),
    .tick_o     (tick)
  );

  assign dx = $signed({1'b0, player_x} - {1'b0, bx_q});
  assign dy = $signed({1'b0, player_y} - {1'b0, by_q});
  assign adx = dx[9] ? 10'(-dx) : 10'(dx);
  assign ady = dy[9] ? 10'(-dy) : 10'(dy);
  assign pick_y    = ady > adx;
  assign pick_neg  = pick_y ? dy[9] : dx[9];
  assign pick_null = (dx == 10'sd0) && (dy == 10'sd0);

  // candidate for the primary (in PICK) or secondary (in COMMIT) axis
  assign c_axy  = (state_q == S_PICK) ? pick_y : ~axy_q;
  assign c_neg  = (state_q == S_PICK) ? pick_neg : sneg_q;
  assign c_step = c_neg ? 11'h7FF : 11'd1;
  assign cx = {2'b0, bx_q} + (c_axy ? 11'd0 : c_step);
  assign cy = {2'b0, by_q} + (c_axy ? c_step : 11'd0);

  assign cand_bad = nx_q[10] | ny_q[10] |
                    (nx_q < 11'(MAP_X0)) |
                    (ny_q < 11'(MAP_Y0));
  assign mv_ok    = !null_q && !blk_q;
  assign do_retry = !null_q && blk_q && !retry_q && snz_q;
  assign cbx = (mv_ok && !axy_q) ? nx_q[8:0] : bx_q;
  assign cby = (mv_ok &&  axy_q) ? ny_q[8:0] : by_q;
  assign catch_hit = near(player_x, cbx) && near(player_y, cby);
  assign dir_b = base_of(axy_q, neg_q);

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      state_q  <= S_IDLE;
      bx_q     <= 9'(START_X);
      by_q     <= 9'(START_Y);
      st_q     <= 4'(RIGHT1);
      req_q    <= 1'b0;
      caught_q <= 1'b0;
      row_q    <= '0;
      col_q    <= '0;
      nx_q     <= '0;
      ny_q     <= '0;
      axy_q    <= 1'b0;
      neg_q    <= 1'b0;
      snz_q    <= 1'b0;
      sneg_q   <= 1'b0;
      retry_q  <= 1'b0;
      wa_q     <= 1'b0;
      blk_q    <= 1'b0;
      null_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      st_q     <= st_d;
      req_q    <= req_d;
      caught_q <= caught_d;
      row_q    <= row_d;
      col_q    <= col_d;
      nx_q     <= nx_d;
      ny_q     <= ny_d;
      axy_q    <= axy_d;
      neg_q    <= neg_d;
      snz_q    <= snz_d;
      sneg_q   <= sneg_d;
      retry_q  <= retry_d;
      wa_q     <= wa_d;
      blk_q    <= blk_d;
      null_q   <= null_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: state_d = S_WAIT;
      S_WAIT: if (tick) state_d = S_PICK;
      S_PICK: state_d = pick_null ? S_COMMIT : S_LOOK_A;
      S_LOOK_A: begin
        if (!req_q && cand_bad)    state_d = S_COMMIT;
        else if (req_q && map_ack) state_d = S_LOOK_B;
      end
      S_LOOK_B: if (req_q && map_ack) state_d = S_COMMIT;
      S_COMMIT: begin
        if (do_retry)       state_d = S_LOOK_A;
        else if (catch_hit) state_d = S_CAUGHT;
        else                state_d = S_WAIT;
      end
      S_CAUGHT: state_d = S_CAUGHT;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bx_d = bx_q; by_d = by_q; st_d = st_q;
    req_d = req_q; caught_d = caught_q;
    row_d = row_q; col_d = col_q;
    nx_d = nx_q; ny_d = ny_q;
    axy_d = axy_q; neg_d = neg_q;
    snz_d = snz_q; sneg_d = sneg_q;
    retry_d = retry_q; wa_d = wa_q;
    blk_d = blk_q; null_d = null_q;
    unique case (state_q)
      S_PICK: begin
        nx_d    = cx;
        ny_d    = cy;
        axy_d   = pick_y;
        neg_d   = pick_neg;
        snz_d   = pick_y ? (dx != 10'sd0) : (dy != 10'sd0);
        sneg_d  = pick_y ? dx[9] : dy[9];
        retry_d = 1'b0;
        blk_d   = 1'b0;
        null_d  = pick_null;
      end
      S_LOOK_A: begin
        if (!req_q) begin
          if (cand_bad) begin
            blk_d = 1'b1;
          end else begin
            req_d = 1'b1;
            row_d = cell_of(ny_q, MAP_Y0);
            col_d = cell_of(nx_q, MAP_X0);
          end
        end else if (map_ack) begin
          req_d = 1'b0;
          wa_d  = map_wall;
        end
      end
      S_LOOK_B: begin
        if (!req_q) begin
          req_d = 1'b1;
          row_d = cell_of(ny_q + 11'(SPRITE), MAP_Y0);
          col_d = cell_of(nx_q + 11'(SPRITE), MAP_X0);
        end else if (map_ack) begin
          req_d = 1'b0;
          blk_d = wa_q | map_wall;
        end
      end
      S_COMMIT: begin
        if (do_retry) begin
          retry_d = 1'b1;
          axy_d   = ~axy_q;
          neg_d   = sneg_q;
          nx_d    = cx;
          ny_d    = cy;
          blk_d   = 1'b0;
        end else begin
          bx_d     = cbx;
          by_d     = cby;
          caught_d = catch_hit;
          // a blocked step still turns the sprite to face the attempt
          if (null_q)
            st_d = 4'((st_q / 4'd3) * 4'd3);
          else if (mv_ok)
            st_d = (st_q == dir_b + 4'd1) ? dir_b + 4'd2
                                          : dir_b + 4'd1;
          else
            st_d = dir_b;
        end
      end
      default: ;
    endcase
  end

  assign map_req    = req_q;
  assign map_row    = row_q;
  assign map_col    = col_q;
  assign boss_x     = bx_q;
  assign boss_y     = by_q;
  assign boss_state = st_q;
  assign caught     = caught_q;

endmodule

// File: tb/tb_boss_chase_ctrl.sv
// Self-checking bench for boss_chase_ctrl: directed scenarios plus a
// randomized chase against a per-move reference model.
module tb_boss_chase_ctrl;

  localparam int TD = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [8:0] player_x = '0;
  logic [8:0] player_y = '0;
  logic [1:0] key_find = '0;
  logic       map_ack = 1'b0;
  logic       map_wall = 1'b0;
  logic       map_req;
  logic [5:0] map_row, map_col;
  logic [8:0] boss_x, boss_y;
  logic [3:0] boss_state;
  logic       caught;

  int vectors = 0;
  int errors = 0;
  int cyc = 0;

  bit walls [64][64];
  int ack_delay = 0;
  bit rand_delay = 0;
  bit noise = 0;
  bit chk_len = 0;

  int mx, my, mst;
  bit mc;

  boss_chase_ctrl #(
    .TICK_DIV(TD), .START_X(240), .START_Y(185), .CATCH_DIST(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .player_x(player_x), .player_y(player_y), .key_find(key_find),
    .map_req(map_req), .map_row(map_row), .map_col(map_col),
    .map_ack(map_ack), .map_wall(map_wall),
    .boss_x(boss_x), .boss_y(boss_y), .boss_state(boss_state),
    .caught(caught)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // map port responder and handshake protocol watcher
  bit pend = 0;
  int cnt = 0;
  int run = 0;
  logic prev_req = 1'b0, prev_ack = 1'b0;
  logic [5:0] prev_row = '0, prev_col = '0;

  always @(negedge clk) begin
    if (prev_req === 1'b1 && prev_ack === 1'b1) begin
      vectors++;
      if (map_req !== 1'b0) begin
        errors++;
        $display("FAIL req_drop: req=%b after ack, want 0", map_req);
      end
    end
    if (prev_req === 1'b1 && prev_ack === 1'b0 && map_req === 1'b1) begin
      vectors++;
      if ({map_row, map_col} !== {prev_row, prev_col}) begin
        errors++;
        $display("FAIL req_stable: row/col=%0d/%0d want %0d/%0d",
                 map_row, map_col, prev_row, prev_col);
      end
    end
    if (map_req === 1'b1) run++;
    else begin
      if (prev_req === 1'b1 && prev_ack === 1'b1 && chk_len) begin
        vectors++;
        if (run != ack_delay + 1) begin
          errors++;
          $display("FAIL req_len: %0d req cycles, want %0d",
                   run, ack_delay + 1);
        end
      end
      run = 0;
    end
    if (map_req !== 1'b1) begin
      pend = 0;
      map_ack = noise ? 1'($urandom % 2) : 1'b0;
      map_wall = 1'($urandom % 2);
    end else begin
      if (!pend) begin
        pend = 1;
        cnt = rand_delay ? int'($urandom_range(0, 3)) : ack_delay;
      end
      if (cnt == 0) begin
        map_ack = 1'b1;
        map_wall = walls[map_row][map_col];
      end else begin
        map_ack = 1'b0;
        cnt--;
      end
    end
    prev_req = map_req;
    prev_ack = map_ack;
    prev_row = map_row;
    prev_col = map_col;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic restart();
    enable = 1'b0;
    cycles(2);
    enable = 1'b1;
  endtask

  task automatic clear_map();
    foreach (walls[i, j]) walls[i][j] = 1'b0;
  endtask

  // ---- reference model: one move attempt per tick ----
  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  function automatic int sgn(input int v);
    return v < 0 ? -1 : 1;
  endfunction

  function automatic bit free_at(input int nx, input int ny);
    if (nx < 60 || ny < 30) return 1'b0;
    return !walls[(ny - 30) / 5][(nx - 60) / 5] &&
           !walls[(ny - 20) / 5][(nx - 50) / 5];
  endfunction

  function automatic int face(input int ddx, input int ddy);
    if (ddx > 0) return 3;
    if (ddx < 0) return 6;
    if (ddy < 0) return 0;
    return 9;
  endfunction

  task automatic model_reset();
    mx = 240; my = 185; mst = 3; mc = 0;
  endtask

  task automatic model_step(input int px, input int py);
    int dx, dy, tx, ty, b;
    bit ydom, moved;
    dx = px - mx;
    dy = py - my;
    if (dx == 0 && dy == 0) begin
      mst = mst / 3 * 3;
    end else begin
      ydom = iabs(dy) > iabs(dx);
      tx = ydom ? mx : mx + sgn(dx);
      ty = ydom ? my + sgn(dy) : my;
      moved = free_at(tx, ty);
      if (!moved && (ydom ? dx != 0 : dy != 0)) begin
        tx = ydom ? mx + sgn(dx) : mx;
        ty = ydom ? my : my + sgn(dy);
        moved = free_at(tx, ty);
      end
      b = face(tx - mx, ty - my);
      if (moved) begin
        mst = (mst == b + 1) ? b + 2 : b + 1;
        mx = tx;
        my = ty;
      end else begin
        mst = b;
      end
    end
    mc = iabs(px - mx) < 8 && iabs(py - my) < 8;
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b1;
    cycles(3);
    vectors++;
    if ({boss_x, boss_y, boss_state, caught, map_req, map_row, map_col}
        !== {9'd240, 9'd185, 4'd3, 1'b0, 1'b0, 6'd0, 6'd0}) begin
      errors++;
      $display("FAIL reset: x=%0d y=%0d st=%0d c=%b req=%b rc=%0d/%0d want 240 185 3 0 0 0/0",
               boss_x, boss_y, boss_state, caught, map_req, map_row, map_col);
    end
    enable = 1'b0;
    rst_n = 1'b1;
    cycles(2);
  endtask

  task automatic test_step_x();
    clear_map();
    ack_delay = 0;
    player_x = 9'd100; player_y = 9'd185;
    restart();
    cycles(TD + 40);
    vectors++;
    if ({boss_x, boss_y, boss_state, caught} !== {9'd239, 9'd185, 4'd7, 1'b0}) begin
      errors++;
      $display("FAIL step_x: x=%0d y=%0d st=%0d c=%b want 239 185 7 0",
               boss_x, boss_y, boss_state, caught);
    end
  endtask

  task automatic test_blocked_up();
    clear_map();
    walls[30][36] = 1'b1;
    player_x = 9'd240; player_y = 9'd100;
    restart();
    cycles(TD + 40);
    vectors++;
    if ({boss_x, boss_y, boss_state, caught} !== {9'd240, 9'd185, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL blocked_up: x=%0d y=%0d st=%0d c=%b want 240 185 0 0",
               boss_x, boss_y, boss_state, caught);
    end
  endtask

  task automatic test_retry();
    clear_map();
    walls[31][35] = 1'b1;
    player_x = 9'd220; player_y = 9'd180;
    restart();
    cycles(TD + 40);
    vectors++;
    if ({boss_x, boss_y, boss_state, caught} !== {9'd240, 9'd184, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL retry_y: x=%0d y=%0d st=%0d c=%b want 240 184 1 0",
               boss_x, boss_y, boss_state, caught);
    end
  endtask

  task automatic test_catch();
    clear_map();
    player_x = 9'd245; player_y = 9'd190;
    restart();
    cycles(TD + 40);
    vectors++;
    if ({boss_x, boss_y, boss_state, caught} !== {9'd241, 9'd185, 4'd4, 1'b1}) begin
      errors++;
      $display("FAIL catch: x=%0d y=%0d st=%0d c=%b want 241 185 4 1",
               boss_x, boss_y, boss_state, caught);
    end
    player_x = 9'd100; player_y = 9'd100;
    cycles(2 * TD);
    vectors++;
    if ({boss_x, boss_y, boss_state, caught, map_req}
        !== {9'd241, 9'd185, 4'd4, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL catch_hold: x=%0d y=%0d st=%0d c=%b req=%b want 241 185 4 1 0",
               boss_x, boss_y, boss_state, caught, map_req);
    end
    enable = 1'b0;
    cycles(1);
    vectors++;
    if ({boss_x, boss_y, boss_state, caught} !== {9'd240, 9'd185, 4'd3, 1'b0}) begin
      errors++;
      $display("FAIL catch_clear: x=%0d y=%0d st=%0d c=%b want 240 185 3 0",
               boss_x, boss_y, boss_state, caught);
    end
  endtask

  task automatic test_handshake();
    bit seen;
    clear_map();
    ack_delay = 3;
    chk_len = 1;
    player_x = 9'd100; player_y = 9'd185;
    restart();
    cycles(TD + 40);
    vectors++;
    if ({boss_x, boss_y, boss_state} !== {9'd239, 9'd185, 4'd7}) begin
      errors++;
      $display("FAIL slow_ack: x=%0d y=%0d st=%0d want 239 185 7",
               boss_x, boss_y, boss_state);
    end
    seen = 0;
    for (int i = 0; i < 3 * TD; i++) begin
      if (map_req === 1'b1) begin
        seen = 1;
        break;
      end
      cycles(1);
    end
    vectors++;
    if (!seen) begin
      errors++;
      $display("FAIL req_wait: req=%b never rose, want 1", map_req);
    end
    enable = 1'b0;
    cycles(1);
    vectors++;
    if ({map_req, boss_x, boss_y, boss_state} !== {1'b0, 9'd240, 9'd185, 4'd3}) begin
      errors++;
      $display("FAIL abort: req=%b x=%0d y=%0d st=%0d want 0 240 185 3",
               map_req, boss_x, boss_y, boss_state);
    end
    chk_len = 0;
    ack_delay = 0;
  endtask

  task automatic test_cadence(input logic [1:0] keys, input int want);
    int t0, t1;
    logic [8:0] last;
    bit ok;
    clear_map();
    key_find = keys;
    player_x = 9'd60; player_y = 9'd185;
    restart();
    t0 = 0;
    t1 = 0;
    ok = 1;
    for (int k = 0; k < 2; k++) begin
      last = boss_x;
      ok = 0;
      for (int i = 0; i < 4 * TD; i++) begin
        cycles(1);
        if (boss_x !== last) begin
          ok = 1;
          break;
        end
      end
      if (k == 0) t0 = cyc;
      else t1 = cyc;
    end
    vectors++;
    if (!ok || (t1 - t0) != want) begin
      errors++;
      $display("FAIL cadence_k%0d: interval %0d (moved=%b) want %0d",
               keys, t1 - t0, ok, want);
    end
    key_find = 2'd0;
  endtask

  task automatic test_random();
    bit fresh;
    int px, py;
    foreach (walls[i, j]) walls[i][j] = ($urandom % 4) == 0;
    rand_delay = 1;
    noise = 1;
    fresh = 1;
    model_reset();
    for (int k = 0; k < 120; k++) begin
      if ($urandom % 8 == 0) begin
        px = mx;
        py = my;
      end else begin
        px = mx + int'($urandom_range(0, 60)) - 30;
        py = my + int'($urandom_range(0, 60)) - 30;
      end
      px = px < 60 ? 60 : (px > 360 ? 360 : px);
      py = py < 30 ? 30 : (py > 330 ? 330 : py);
      player_x = 9'(px);
      player_y = 9'(py);
      if (fresh) begin
        restart();
        cycles(TD + 40);
        fresh = 0;
      end else begin
        cycles(TD);
      end
      model_step(px, py);
      vectors++;
      if ({boss_x, boss_y, boss_state, caught}
          !== {9'(mx), 9'(my), 4'(mst), mc}) begin
        errors++;
        $display("FAIL rand_%0d: x=%0d y=%0d st=%0d c=%b want %0d %0d %0d %b",
                 k, boss_x, boss_y, boss_state, caught, mx, my, mst, mc);
      end
      if (mc) begin
        fresh = 1;
        model_reset();
      end
    end
    rand_delay = 0;
    noise = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_step_x();
    test_blocked_up();
    test_retry();
    test_catch();
    test_handshake();
    test_cadence(2'd0, TD);
`ifdef BOSS_SPEEDUP_EN
    test_cadence(2'd3, TD / 2);
`else
    test_cadence(2'd3, TD);
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
